// File: rtl/ofdm_pkg.sv
// Shared types and constants for the 4-subcarrier BPSK OFDM transmitter.
//   N_SC       : subcarriers per symbol (bits per group)
//   OUT_W      : output sample width, two's complement
//   BIT_PERIOD : clocks per input bit and per output sample
`timescale 1ns/1ps
package ofdm_pkg;

  localparam int unsigned N_SC       = 4;
  localparam int unsigned OUT_W      = 4;
  localparam int unsigned BIT_PERIOD = 2;
  localparam int unsigned PH_W       = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
  localparam int unsigned CNT_W      = $clog2(N_SC);

  typedef logic signed [OUT_W-1:0] sample_t;

  // All four time-domain samples of one symbol.
  typedef struct packed {
    sample_t x3;
    sample_t x2;
    sample_t x1;
    sample_t x0;
  } idft_out_t;

  // Samples still to be streamed after x0 has gone out.
  typedef struct packed {
    sample_t x3;
    sample_t x2;
    sample_t x1;
  } tail_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } run_state_e;

  // BPSK: 1 -> +1, 0 -> -1
  function automatic sample_t bpsk_map(input logic b);
    return b ? sample_t'(1) : sample_t'(-1);
  endfunction

endpackage

// File: rtl/ofdm_idft4.sv
// Combinational 4-point IDFT (real part, unscaled) of four BPSK-mapped bits.
//   bits_i      : b3..b0, bit k drives subcarrier X_k
//   samples_c_o : x0..x3 time samples, range -4..+4
`timescale 1ns/1ps
module ofdm_idft4
  import ofdm_pkg::*;
(
  input  logic [N_SC-1:0] bits_i,
  output idft_out_t       samples_c_o
);

  sample_t sym0, sym1, sym2, sym3;

  assign sym0 = bpsk_map(bits_i[0]);
  assign sym1 = bpsk_map(bits_i[1]);
  assign sym2 = bpsk_map(bits_i[2]);
  assign sym3 = bpsk_map(bits_i[3]);

  // Odd bins cancel in the real part of x1/x3; the +/-4 range fits OUT_W without saturation.
  assign samples_c_o.x0 = sym0 + sym1 + sym2 + sym3;
  assign samples_c_o.x1 = sym0 - sym2;
  assign samples_c_o.x2 = sym0 - sym1 + sym2 - sym3;
  assign samples_c_o.x3 = sym0 - sym2;

endmodule

// File: rtl/ofdm_tx.sv
// Minimal 4-subcarrier BPSK OFDM modulator: deserialises the bit stream, runs a
// 4-point IDFT per group and streams the real samples out, one per input bit.
//   clk   : system clock, rising edge
//   reset : asynchronous active-low reset
//   x_in  : serial data bit, held BIT_PERIOD clocks, LSB of group first
//   x_out : signed IDFT sample, registered, held BIT_PERIOD clocks
`timescale 1ns/1ps
module ofdm_tx
  import ofdm_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             x_in,
  output logic [OUT_W-1:0] x_out
);

  logic [PH_W-1:0]  phase_q,   phase_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [N_SC-2:0]  sreg_q,    sreg_d;
  tail_t            tail_q,    tail_d;
  logic [CNT_W-1:0] out_idx_q, out_idx_d;
  sample_t          x_out_q,   x_out_d;
  run_state_e       state_q,   state_d;

  logic             sample_en_c;
  logic [N_SC-1:0]  idft_bits_c;
  idft_out_t        idft_c;

  // The final bit bypasses the shift register so x0 leaves on the edge that captures it.
  assign idft_bits_c = {x_in, sreg_q};

  ofdm_idft4 u_idft (
    .bits_i      (idft_bits_c),
    .samples_c_o (idft_c)
  );

  assign sample_en_c = (phase_q == PH_W'(BIT_PERIOD - 1));

  // Next-state: bit capture, symbol load and output sequencing.
  always_comb begin
    phase_d   = sample_en_c ? '0 : phase_q + PH_W'(1);
    bit_cnt_d = bit_cnt_q;
    sreg_d    = sreg_q;
    tail_d    = tail_q;
    out_idx_d = out_idx_q;
    x_out_d   = x_out_q;
    state_d   = state_q;

    if (sample_en_c) begin
      bit_cnt_d = bit_cnt_q + CNT_W'(1);
      if (bit_cnt_q == CNT_W'(N_SC - 1)) begin
        x_out_d   = idft_c.x0;
        tail_d    = '{x3: idft_c.x3, x2: idft_c.x2, x1: idft_c.x1};
        out_idx_d = CNT_W'(1);
        state_d   = ST_RUN;
      end else begin
        sreg_d[bit_cnt_q] = x_in;
        // out_idx wraps to 0 after x3, which holds the last sample until the next load.
        if (state_q == ST_RUN && out_idx_q != '0) begin
          out_idx_d = out_idx_q + CNT_W'(1);
          unique case (out_idx_q)
            CNT_W'(1): x_out_d = tail_q.x1;
            CNT_W'(2): x_out_d = tail_q.x2;
            CNT_W'(3): x_out_d = tail_q.x3;
            default:   x_out_d = x_out_q;
          endcase
        end
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_q   <= '0;
      bit_cnt_q <= '0;
      sreg_q    <= '0;
      tail_q    <= '0;
      out_idx_q <= '0;
      x_out_q   <= '0;
      state_q   <= ST_IDLE;
    end else begin
      phase_q   <= phase_d;
      bit_cnt_q <= bit_cnt_d;
      sreg_q    <= sreg_d;
      tail_q    <= tail_d;
      out_idx_q <= out_idx_d;
      x_out_q   <= x_out_d;
      state_q   <= state_d;
    end
  end

  assign x_out = x_out_q;

endmodule

// File: tb/tb_ofdm_tx.sv
// Testbench for ofdm_tx: serial bit stimulus checked against a cosine-sum IDFT model.
`timescale 1ns/1ps
module tb_ofdm_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic       x_in;
  logic [3:0] x_out;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: bits of the group being collected, samples still to emit.
  int         m_bits[$];
  int         m_pend[$];
  logic [3:0] m_cur;

  ofdm_tx dut (
    .clk   (clk),
    .reset (reset),
    .x_in  (x_in),
    .x_out (x_out)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, x_out=%h", x_out);
    $fatal(1, "watchdog");
  end

  function automatic void model_reset();
    m_bits.delete();
    m_pend.delete();
    m_cur = 4'h0;
  endfunction

  // x[n] = sum_k X_k * cos(2*pi*k*n/4)
  function automatic void model_bit(input logic b);
    int ctab[4];
    int s[4];
    ctab = '{1, 0, -1, 0};
    m_bits.push_back(b ? 1 : 0);
    if (m_bits.size() == 4) begin
      for (int n = 0; n < 4; n++) begin
        s[n] = 0;
        for (int k = 0; k < 4; k++)
          s[n] += (m_bits[k] != 0 ? 1 : -1) * ctab[(k * n) % 4];
      end
      m_cur = 4'(s[0]);
      m_pend.delete();
      for (int n = 1; n < 4; n++) m_pend.push_back(s[n]);
      m_bits.delete();
    end else if (m_pend.size() > 0) begin
      m_cur = 4'(m_pend.pop_front());
    end
  endfunction

  // Drive one bit for two clocks: check the hold on the first edge, the update on the second.
  task automatic send_bit(input logic b, input string tag);
    logic [3:0] prev;
    prev = m_cur;
    x_in = b;
    @(posedge clk); #1;
    n_vec++;
    if (x_out !== prev) begin
      n_err++;
      $display("FAIL %s hold: x_out=%h expected %h", tag, x_out, prev);
    end
    @(posedge clk);
    model_bit(b);
    #1;
    n_vec++;
    if (x_out !== m_cur) begin
      n_err++;
      $display("FAIL %s sample: x_out=%h expected %h", tag, x_out, m_cur);
    end
  endtask

  task automatic send_group(input logic [3:0] g, input string tag);
    for (int i = 0; i < 4; i++) send_bit(g[i], tag);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    x_in  = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      #30;
      n_vec++;
      if (x_out !== 4'h0) begin
        n_err++;
        $display("FAIL reset_hold: x_out=%h expected 0", x_out);
      end
    end
    #10;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_pattern_0110();
    for (int i = 0; i < 3; i++) send_group(4'b0110, "pattern_0110");
  endtask

  task automatic test_fixed_groups();
    send_group(4'b0000, "group_0000");
    send_group(4'b1111, "group_1111");
    send_group(4'b0001, "group_1000");
    send_group(4'b0110, "group_flush");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++)
      send_group((i % 2 == 0) ? 4'b0110 : 4'b1111, "back_to_back");
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++)
      send_group(4'($urandom_range(0, 15)), "random");
  endtask

  task automatic test_reset_mid();
    // Previous group 1000 leaves nonzero samples in flight when reset hits.
    send_group(4'b0001, "mid_pre");
    send_bit(1'b1, "mid_partial");
    send_bit(1'b0, "mid_partial");
    #3;
    reset = 1'b0;
    model_reset();
    #1;
    n_vec++;
    if (x_out !== 4'h0) begin
      n_err++;
      $display("FAIL reset_async: x_out=%h expected 0", x_out);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_vec++;
      if (x_out !== 4'h0) begin
        n_err++;
        $display("FAIL reset_mid_hold: x_out=%h expected 0", x_out);
      end
    end
    @(negedge clk);
    reset = 1'b1;
    send_group(4'b0001, "after_reset");
    send_group(4'b0110, "after_reset");
    send_group(4'($urandom_range(0, 15)), "after_reset");
    send_group(4'b1111, "after_reset");
  endtask

  initial begin
    test_reset();
    test_pattern_0110();
    test_fixed_groups();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
